// File: rtl/sobel_scheduler_pkg.sv
// Shared parameters for the sobel frame scheduler: widths, window size and FSM state codes.
package sobel_scheduler_pkg;

    localparam int unsigned PIXEL_WIDTH_OUT     = 8;
    localparam int unsigned MAX_RESOLUTION_BITS = 8;
    localparam int unsigned MEM_ADDR_BITS_DEF   = 16;
    localparam int unsigned WINDOW_ROWS         = 3;
    localparam int unsigned RES_CNT_BITS        = 2 * MAX_RESOLUTION_BITS;
    localparam int unsigned ROW_IDX_BITS        = 2;
    localparam int unsigned STATE_BITS          = 3;

    localparam logic [STATE_BITS-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_BITS-1:0] ST_CHECK     = 3'd1;
    localparam logic [STATE_BITS-1:0] ST_STRIP_GAP = 3'd2;
    localparam logic [STATE_BITS-1:0] ST_FETCH     = 3'd3;
    localparam logic [STATE_BITS-1:0] ST_WAIT_ACK  = 3'd4;
    localparam logic [STATE_BITS-1:0] ST_PUSH      = 3'd5;
    localparam logic [STATE_BITS-1:0] ST_DRAIN     = 3'd6;
    localparam logic [STATE_BITS-1:0] ST_DONE      = 3'd7;

    // A frame needs at least one full 3x3 window in both directions.
    function automatic logic cfg_valid(input logic [MAX_RESOLUTION_BITS-1:0] w,
                                       input logic [MAX_RESOLUTION_BITS-1:0] h);
        return (w >= MAX_RESOLUTION_BITS'(WINDOW_ROWS)) &&
               (h >= MAX_RESOLUTION_BITS'(WINDOW_ROWS));
    endfunction

endpackage

// File: rtl/sobel_addr_gen.sv
// Strip/column/row walker producing row-major pixel addresses with adders only.
module sobel_addr_gen
    import sobel_scheduler_pkg::*;
#(
    parameter int unsigned MEM_ADDR_BITS = MEM_ADDR_BITS_DEF
) (
    input  logic                           clk_i,
    input  logic                           nreset_i,
    input  logic                           init_i,
    input  logic                           advance_i,
    input  logic [MAX_RESOLUTION_BITS-1:0] width_i,
    input  logic [MAX_RESOLUTION_BITS-1:0] height_i,
    output logic [MEM_ADDR_BITS-1:0]       addr_c,
    output logic                           last_strip_o,
    output logic                           last_frame_o
);

    logic [ROW_IDX_BITS-1:0]        row_q, row_d;
    logic [MAX_RESOLUTION_BITS-1:0] col_q, col_d;
    logic [MAX_RESOLUTION_BITS-1:0] strip_q, strip_d;
    logic [MEM_ADDR_BITS-1:0]       strip_base_q, strip_base_d;
    logic [MEM_ADDR_BITS-1:0]       col_addr_q, col_addr_d;
    logic [MEM_ADDR_BITS-1:0]       row_off_q, row_off_d;
    logic                           last_strip_q, last_strip_d;
    logic                           last_frame_q, last_frame_d;

    logic [MEM_ADDR_BITS-1:0] width_ext;
    logic                     col_end;
    logic                     row_end;
    logic                     strip_end;

    assign width_ext = MEM_ADDR_BITS'(width_i);
    assign row_end   = (row_q == ROW_IDX_BITS'(WINDOW_ROWS - 1));
    assign col_end   = (col_q == width_i - MAX_RESOLUTION_BITS'(1));
    assign strip_end = row_end && col_end;
    assign addr_c    = col_addr_q + row_off_q;

    // Last-pixel flags describe the pixel just consumed, so they survive the advance.
    always_comb begin
        row_d        = row_q;
        col_d        = col_q;
        strip_d      = strip_q;
        strip_base_d = strip_base_q;
        col_addr_d   = col_addr_q;
        row_off_d    = row_off_q;
        last_strip_d = last_strip_q;
        last_frame_d = last_frame_q;
        if (init_i) begin
            row_d        = '0;
            col_d        = '0;
            strip_d      = '0;
            strip_base_d = '0;
            col_addr_d   = '0;
            row_off_d    = '0;
            last_strip_d = 1'b0;
            last_frame_d = 1'b0;
        end else if (advance_i) begin
            last_strip_d = strip_end;
            last_frame_d = strip_end &&
                           (strip_q == height_i - MAX_RESOLUTION_BITS'(WINDOW_ROWS));
            if (!row_end) begin
                row_d     = row_q + ROW_IDX_BITS'(1);
                row_off_d = row_off_q + width_ext;
            end else begin
                row_d     = '0;
                row_off_d = '0;
                if (!col_end) begin
                    col_d      = col_q + MAX_RESOLUTION_BITS'(1);
                    col_addr_d = col_addr_q + MEM_ADDR_BITS'(1);
                end else begin
                    col_d        = '0;
                    strip_d      = strip_q + MAX_RESOLUTION_BITS'(1);
                    strip_base_d = strip_base_q + width_ext;
                    col_addr_d   = strip_base_q + width_ext;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            row_q        <= '0;
            col_q        <= '0;
            strip_q      <= '0;
            strip_base_q <= '0;
            col_addr_q   <= '0;
            row_off_q    <= '0;
            last_strip_q <= 1'b0;
            last_frame_q <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            strip_q      <= strip_d;
            strip_base_q <= strip_base_d;
            col_addr_q   <= col_addr_d;
            row_off_q    <= row_off_d;
            last_strip_q <= last_strip_d;
            last_frame_q <= last_frame_d;
        end
    end

    assign last_strip_o = last_strip_q;
    assign last_frame_o = last_frame_q;

endmodule

// File: rtl/sobel_scheduler.sv
// Frame scheduler: walks a frame in 3-row strips, fetches pixels from memory and
// streams them to the sobel window controller, then waits for all results.
module sobel_scheduler
    import sobel_scheduler_pkg::*;
#(
    parameter int unsigned MEM_ADDR_BITS = MEM_ADDR_BITS_DEF
) (
    input  logic                           clk_i,
    input  logic                           nreset_i,
    input  logic                           start_i,
    input  logic                           abort_i,
    input  logic [MAX_RESOLUTION_BITS-1:0] cfg_width_i,
    input  logic [MAX_RESOLUTION_BITS-1:0] cfg_height_i,
    output logic                           mem_req_o,
    output logic [MEM_ADDR_BITS-1:0]       mem_addr_o,
    input  logic                           mem_ack_i,
    input  logic [PIXEL_WIDTH_OUT-1:0]     mem_data_i,
    output logic                           start_sobel_o,
    output logic                           px_rdy_o,
    output logic [PIXEL_WIDTH_OUT-1:0]     px_o,
    input  logic                           sobel_rdy_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           cfg_err_o
);

    logic [STATE_BITS-1:0]          state_q, state_d;
    logic                           gap_q, gap_d;
    logic [MAX_RESOLUTION_BITS-1:0] cfg_width_q, cfg_width_d;
    logic [MAX_RESOLUTION_BITS-1:0] cfg_height_q, cfg_height_d;
    logic [RES_CNT_BITS-1:0]        expected_q, expected_d;
    logic [RES_CNT_BITS-1:0]        res_cnt_q, res_cnt_d;
    logic                           mem_req_q, mem_req_d;
    logic [MEM_ADDR_BITS-1:0]       mem_addr_q, mem_addr_d;
    logic                           start_sobel_q, start_sobel_d;
    logic                           px_rdy_q, px_rdy_d;
    logic [PIXEL_WIDTH_OUT-1:0]     px_q, px_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           cfg_err_q, cfg_err_d;

    logic                     gen_init_c;
    logic                     gen_adv_c;
    logic [MEM_ADDR_BITS-1:0] gen_addr_c;
    logic                     gen_last_strip;
    logic                     gen_last_frame;

    sobel_addr_gen #(
        .MEM_ADDR_BITS(MEM_ADDR_BITS)
    ) u_addr_gen (
        .clk_i       (clk_i),
        .nreset_i    (nreset_i),
        .init_i      (gen_init_c),
        .advance_i   (gen_adv_c),
        .width_i     (cfg_width_q),
        .height_i    (cfg_height_q),
        .addr_c      (gen_addr_c),
        .last_strip_o(gen_last_strip),
        .last_frame_o(gen_last_frame)
    );

    // Next-state and registered-output logic; outputs follow the next state.
    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        cfg_width_d  = cfg_width_q;
        cfg_height_d = cfg_height_q;
        expected_d   = expected_q;
        res_cnt_d    = res_cnt_q;
        px_d         = px_q;
        cfg_err_d    = cfg_err_q;
        gen_init_c   = 1'b0;
        gen_adv_c    = 1'b0;

        if (busy_q && sobel_rdy_i && (res_cnt_q < expected_q)) begin
            res_cnt_d = res_cnt_q + RES_CNT_BITS'(1);
        end

        if (abort_i) begin
            state_d = ST_IDLE;
            px_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d      = ST_CHECK;
                        cfg_width_d  = cfg_width_i;
                        cfg_height_d = cfg_height_i;
                        cfg_err_d    = 1'b0;
                        res_cnt_d    = '0;
                        expected_d   = '0;
                        gen_init_c   = 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (!cfg_valid(cfg_width_q, cfg_height_q)) begin
                        state_d   = ST_DONE;
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d    = ST_STRIP_GAP;
                        gap_d      = 1'b0;
                        expected_d =
                            RES_CNT_BITS'(cfg_height_q - MAX_RESOLUTION_BITS'(WINDOW_ROWS - 1)) *
                            RES_CNT_BITS'(cfg_width_q - MAX_RESOLUTION_BITS'(WINDOW_ROWS - 1));
                    end
                end
                ST_STRIP_GAP: begin
                    if (gap_q) begin
                        state_d = ST_FETCH;
                    end else begin
                        gap_d = 1'b1;
                    end
                end
                // The request is already on the bus in FETCH, so a same-cycle ack is honoured.
                ST_FETCH, ST_WAIT_ACK: begin
                    if (mem_ack_i) begin
                        state_d   = ST_PUSH;
                        px_d      = mem_data_i;
                        gen_adv_c = 1'b1;
                    end else begin
                        state_d = ST_WAIT_ACK;
                    end
                end
                ST_PUSH: begin
                    if (gen_last_frame) begin
                        state_d = ST_DRAIN;
                    end else if (gen_last_strip) begin
                        state_d = ST_STRIP_GAP;
                        gap_d   = 1'b0;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (res_cnt_q == expected_q) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        mem_req_d     = (state_d == ST_FETCH) || (state_d == ST_WAIT_ACK);
        mem_addr_d    = mem_req_d ? gen_addr_c : '0;
        px_rdy_d      = (state_d == ST_PUSH);
        start_sobel_d = (state_d == ST_FETCH) || (state_d == ST_WAIT_ACK) ||
                        (state_d == ST_PUSH)  || (state_d == ST_DRAIN);
        busy_d        = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d        = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q       <= ST_IDLE;
            gap_q         <= 1'b0;
            cfg_width_q   <= '0;
            cfg_height_q  <= '0;
            expected_q    <= '0;
            res_cnt_q     <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            start_sobel_q <= 1'b0;
            px_rdy_q      <= 1'b0;
            px_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            cfg_width_q   <= cfg_width_d;
            cfg_height_q  <= cfg_height_d;
            expected_q    <= expected_d;
            res_cnt_q     <= res_cnt_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            start_sobel_q <= start_sobel_d;
            px_rdy_q      <= px_rdy_d;
            px_q          <= px_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign start_sobel_o = start_sobel_q;
    assign px_rdy_o      = px_rdy_q;
    assign px_o          = px_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_sobel_scheduler.sv
// Self-checking bench for sobel_scheduler: table vectors, random frames and corner sequences.
module tb_sobel_scheduler;
    import sobel_scheduler_pkg::*;

    localparam int unsigned AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                           nreset;
    logic                           start;
    logic                           abort;
    logic [MAX_RESOLUTION_BITS-1:0] cfg_w;
    logic [MAX_RESOLUTION_BITS-1:0] cfg_h;
    logic                           mem_req_o;
    logic [AW-1:0]                  mem_addr_o;
    logic                           mem_ack_r;
    logic                           inject_ack;
    logic                           mem_ack;
    logic [PIXEL_WIDTH_OUT-1:0]     mem_data_r;
    logic                           start_sobel_o;
    logic                           px_rdy_o;
    logic [PIXEL_WIDTH_OUT-1:0]     px_o;
    logic                           sobel_r;
    logic                           inject_rdy;
    logic                           sobel_rdy;
    logic                           busy_o;
    logic                           done_o;
    logic                           cfg_err_o;

    assign mem_ack   = mem_ack_r | inject_ack;
    assign sobel_rdy = sobel_r | inject_rdy;

    sobel_scheduler #(.MEM_ADDR_BITS(AW)) dut (
        .clk_i        (clk),
        .nreset_i     (nreset),
        .start_i      (start),
        .abort_i      (abort),
        .cfg_width_i  (cfg_w),
        .cfg_height_i (cfg_h),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack),
        .mem_data_i   (mem_data_r),
        .start_sobel_o(start_sobel_o),
        .px_rdy_o     (px_rdy_o),
        .px_o         (px_o),
        .sobel_rdy_i  (sobel_rdy),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .cfg_err_o    (cfg_err_o)
    );

    typedef struct {
        int w;
        int h;
        int delay;
        int poke;
        int exp_err;
        int exp_px;
        int exp_res;
        int exp_gaps;
    } vec_t;

    int tests = 0;
    int fails = 0;

    int      dones, res_sent, res_at_done, cycles_to_done, frame_cycles, err_at_done;
    int      unstable, px_long, timeout, run_low, mem_cnt, mem_delay, push_cnt;
    bit      seen_high, mem_en, prev_req, prev_px;
    logic [AW-1:0] prev_addr;
    int      addrs[$];
    int      pxs[$];
    int      gaps[$];

    function automatic int pix(input int a);
        return (a * 37 + 11) % 256;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        dones = 0; res_sent = 0; res_at_done = -1; cycles_to_done = -1;
        frame_cycles = 0; err_at_done = -1; unstable = 0; px_long = 0;
        timeout = 0; run_low = 0; mem_cnt = 0; push_cnt = 0;
        seen_high = 1'b0; prev_req = 1'b0; prev_px = 1'b0; prev_addr = '0;
        mem_ack_r = 1'b0; sobel_r = 1'b0;
        addrs.delete(); pxs.delete(); gaps.delete();
    endtask

    // One clock: observe outputs at the falling edge, then update memory and sobel models.
    task automatic step();
        @(negedge clk);
        frame_cycles++;
        if (mem_req_o) begin
            if (!prev_req) addrs.push_back(int'(mem_addr_o));
            else if (mem_addr_o != prev_addr) unstable++;
        end
        prev_req  = mem_req_o;
        prev_addr = mem_addr_o;
        if (px_rdy_o) begin
            pxs.push_back(int'(px_o));
            if (prev_px) px_long++;
        end
        prev_px = px_rdy_o;
        if (done_o) begin
            dones++;
            if (dones == 1) begin
                cycles_to_done = frame_cycles;
                res_at_done    = res_sent;
                err_at_done    = int'(cfg_err_o);
            end
        end
        if (!busy_o) begin
            seen_high = 1'b0;
            run_low   = 0;
        end else if (start_sobel_o) begin
            if (seen_high && run_low != 0) gaps.push_back(run_low);
            run_low   = 0;
            seen_high = 1'b1;
        end else begin
            run_low++;
        end
        if (mem_ack_r) begin
            mem_ack_r = 1'b0;
            mem_cnt   = 0;
        end else if (mem_req_o && mem_en) begin
            if (mem_cnt >= mem_delay) begin
                mem_ack_r  = 1'b1;
                mem_data_r = PIXEL_WIDTH_OUT'(pix(int'(mem_addr_o)));
            end else begin
                mem_cnt++;
            end
        end else if (!mem_req_o) begin
            mem_cnt = 0;
        end
        sobel_r = 1'b0;
        if (!start_sobel_o) begin
            push_cnt = 0;
        end else if (px_rdy_o) begin
            push_cnt++;
            if (push_cnt >= 9 && (push_cnt - 9) % 3 == 0) begin
                sobel_r = 1'b1;
                res_sent++;
            end
        end
    endtask

    task automatic run_frame(input int w, input int h, input int delay, input int poke);
        clear_mon();
        mem_delay = delay;
        mem_en    = 1'b1;
        cfg_w     = MAX_RESOLUTION_BITS'(w);
        cfg_h     = MAX_RESOLUTION_BITS'(h);
        start     = 1'b1;
        step();
        start = 1'b0;
        while (dones == 0 && frame_cycles < 20000) begin
            if (poke != 0 && frame_cycles == poke) begin
                start = 1'b1;
                cfg_w = MAX_RESOLUTION_BITS'(2);
                cfg_h = MAX_RESOLUTION_BITS'(250);
            end else begin
                start = 1'b0;
            end
            step();
        end
        start   = 1'b0;
        timeout = (dones == 0) ? 1 : 0;
        step();
        step();
    endtask

    task automatic verify_frame(input string tag, input int w, input int h, input int exp_err,
                                input int exp_px, input int exp_res, input int exp_gaps);
        int idx, bad_a, bad_p, bad_g;
        check({tag, " timeout"}, timeout, 0);
        check({tag, " done_pulses"}, dones, 1);
        check({tag, " cfg_err"}, err_at_done, exp_err);
        check({tag, " px_count"}, pxs.size(), exp_px);
        check({tag, " req_count"}, addrs.size(), exp_px);
        check({tag, " results_at_done"}, res_at_done, exp_res);
        check({tag, " strip_gaps"}, gaps.size(), exp_gaps);
        bad_g = 0;
        foreach (gaps[i]) if (gaps[i] != 2) bad_g++;
        check({tag, " gap_len_not_2"}, bad_g, 0);
        check({tag, " addr_unstable"}, unstable, 0);
        check({tag, " px_rdy_multi"}, px_long, 0);
        idx = 0; bad_a = 0; bad_p = 0;
        for (int r = 0; r <= h - 3; r++) begin
            for (int c = 0; c < w; c++) begin
                for (int k = 0; k < 3; k++) begin
                    if (idx < addrs.size() && addrs[idx] != (r + k) * w + c) bad_a++;
                    if (idx < pxs.size() && pxs[idx] != pix((r + k) * w + c)) bad_p++;
                    idx++;
                end
            end
        end
        check({tag, " addr_seq_mismatches"}, bad_a, 0);
        check({tag, " px_data_mismatches"}, bad_p, 0);
        if (exp_err != 0) check({tag, " err_done_latency"}, cycles_to_done, 2);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[8];
    int   exp038[12];

    initial begin
        int n, w, h, d, e;
        nreset = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_w = '0; cfg_h = '0;
        mem_data_r = '0; inject_ack = 1'b0; inject_rdy = 1'b0;
        mem_en = 1'b1; mem_delay = 0;
        clear_mon();

        vecs[0] = '{4, 3, 0, 0,  0, 12, 2, 0};
        vecs[1] = '{5, 4, 0, 0,  0, 30, 6, 1};
        vecs[2] = '{2, 8, 0, 0,  1,  0, 0, 0};
        vecs[3] = '{3, 3, 7, 0,  0,  9, 1, 0};
        vecs[4] = '{8, 2, 1, 0,  1,  0, 0, 0};
        vecs[5] = '{3, 5, 1, 0,  0, 27, 3, 2};
        vecs[6] = '{6, 3, 2, 0,  0, 18, 4, 0};
        vecs[7] = '{5, 4, 1, 40, 0, 30, 6, 1};
        exp038  = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};

        // Reset values
        repeat (3) step();
        check("rst mem_req", mem_req_o, 0);
        check("rst mem_addr", mem_addr_o, 0);
        check("rst start_sobel", start_sobel_o, 0);
        check("rst px_rdy", px_rdy_o, 0);
        check("rst px", px_o, 0);
        check("rst busy", busy_o, 0);
        check("rst done", done_o, 0);
        check("rst cfg_err", cfg_err_o, 0);
        nreset = 1'b1;
        step();

        // Results strobed while idle must be ignored
        clear_mon();
        inject_rdy = 1'b1;
        repeat (4) step();
        inject_rdy = 1'b0;
        step();
        check("idle_rdy busy", busy_o, 0);
        check("idle_rdy done", dones, 0);

        foreach (vecs[i]) begin
            run_frame(vecs[i].w, vecs[i].h, vecs[i].delay, vecs[i].poke);
            verify_frame($sformatf("vec%0d w%0d h%0d", i, vecs[i].w, vecs[i].h),
                         vecs[i].w, vecs[i].h, vecs[i].exp_err, vecs[i].exp_px,
                         vecs[i].exp_res, vecs[i].exp_gaps);
            if (vecs[i].w == 4 && vecs[i].h == 3 && addrs.size() == 12) begin
                e = 0;
                foreach (exp038[j]) if (addrs[j] != exp038[j]) e++;
                check("w4h3 explicit_addrs", e, 0);
            end
            if (vecs[i].w == 5 && vecs[i].h == 4 && addrs.size() > 15)
                check("w5h4 strip2_first_addr", addrs[15], 5);
        end

        // Abort while waiting for an ack, then a late ack
        clear_mon();
        mem_en = 1'b0;
        cfg_w = MAX_RESOLUTION_BITS'(4);
        cfg_h = MAX_RESOLUTION_BITS'(3);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!mem_req_o && n < 20) begin
            step();
            n++;
        end
        check("abort req_seen", mem_req_o, 1);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort mem_req", mem_req_o, 0);
        check("abort start_sobel", start_sobel_o, 0);
        check("abort px_rdy", px_rdy_o, 0);
        check("abort busy", busy_o, 0);
        check("abort done", done_o, 0);
        mem_data_r = PIXEL_WIDTH_OUT'(8'hAA);
        inject_ack = 1'b1;
        step();
        inject_ack = 1'b0;
        repeat (10) step();
        check("abort late_ack px", pxs.size(), 0);
        check("abort late_ack done", dones, 0);
        check("abort late_ack reqs", addrs.size(), 1);
        check("abort late_ack busy", busy_o, 0);
        mem_en = 1'b1;
        run_frame(4, 3, 0, 0);
        verify_frame("restart_after_abort", 4, 3, 0, 12, 2, 0);

        // Reset pulse mid-frame: back to idle, nothing reissued
        clear_mon();
        cfg_w = MAX_RESOLUTION_BITS'(6);
        cfg_h = MAX_RESOLUTION_BITS'(5);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (30) step();
        nreset = 1'b0;
        #1;
        check("midrst mem_req", mem_req_o, 0);
        check("midrst busy", busy_o, 0);
        step();
        nreset = 1'b1;
        clear_mon();
        repeat (20) step();
        check("midrst no_reissue", addrs.size(), 0);
        check("midrst busy_after", busy_o, 0);

        // Random frames against the arithmetic model
        for (int t = 0; t < 12; t++) begin
            w = int'($urandom_range(1, 8));
            h = int'($urandom_range(1, 8));
            d = int'($urandom_range(0, 2));
            e = (w < 3 || h < 3) ? 1 : 0;
            run_frame(w, h, d, 0);
            verify_frame($sformatf("rand%0d w%0d h%0d d%0d", t, w, h, d), w, h, e,
                         e ? 0 : (h - 2) * 3 * w,
                         e ? 0 : (h - 2) * (w - 2),
                         e ? 0 : h - 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
